// File: rtl/rr_req_arbiter.sv
// rr_req_arbiter: round-robin arbiter that shares one resource among 16
// requesters. It issues a registered one-hot grant and the encoded owner
// index. Ownership ends on release, when the owner drops its request, or
// when the hold limit is reached. A limit-forced end raises timeout for one
// cycle. Every grant is followed by exactly one idle cycle, so grants never
// abut.
module rr_req_arbiter #(
  parameter int unsigned HOLD_MAX = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] req_i,
  input  logic        release_i,
  output logic [15:0] gnt_o,
  output logic [3:0]  gnt_idx_o,
  output logic        gnt_vld_o,
  output logic        timeout_o
);

  // A limit of zero turns the forced end off completely.
  localparam bit         TIMEOUT_EN = (HOLD_MAX != 0);
  localparam logic [7:0] HOLD_LIM   = 8'(HOLD_MAX);
  localparam logic [7:0] HOLD_SAT   = 8'hFF;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

  state_e      state_q, state_d;
  logic [3:0]  ptr_q, ptr_d;
  logic [3:0]  cur_q, cur_d;
  logic [7:0]  hold_cnt_q, hold_cnt_d;
  logic [15:0] gnt_q, gnt_d;
  logic [3:0]  gnt_idx_q, gnt_idx_d;
  logic        gnt_vld_q, gnt_vld_d;
  logic        timeout_q, timeout_d;

  logic [3:0]  winner;
  logic        any_req;
  logic        end_normal;
  logic        end_forced;

  // Return the first requester found by scanning circularly upward from
  // start. The 4-bit index wraps naturally from 15 back to 0.
  function automatic logic [3:0] rr_pick(input logic [15:0] r,
                                         input logic [3:0]  start);
    logic [3:0] idx;
    logic [3:0] pick;
    logic       found;
    pick  = '0;
    found = 1'b0;
    for (int i = 0; i < 16; i++) begin
      idx = start + 4'(i);
      if (!found && r[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
    return pick;
  endfunction

  // The hold counter stops at all-ones instead of wrapping. This matters
  // when the limit is disabled and a grant is held for a long time.
  function automatic logic [7:0] hold_inc(input logic [7:0] cnt);
    return (cnt == HOLD_SAT) ? cnt : cnt + 8'd1;
  endfunction

  // Arbitration decode and end-of-grant qualification.
  // Release takes priority over a request drop, and both take priority
  // over the limit. A voluntary end in the limit cycle therefore never
  // reports a timeout.
  always_comb begin
    winner     = rr_pick(req_i, ptr_q);
    any_req    = |req_i;
    end_normal = release_i || !req_i[cur_q];
    end_forced = !end_normal && TIMEOUT_EN && (hold_cnt_q == HOLD_LIM);
  end

  // Next-state and next-output logic. Outputs default to the idle values.
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    cur_d      = cur_q;
    hold_cnt_d = hold_cnt_q;
    gnt_d      = '0;
    gnt_idx_d  = '0;
    gnt_vld_d  = 1'b0;
    timeout_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        // release_i has no effect here. The idle cycle that follows a
        // forced end may also pick the next owner.
        if (any_req) begin
          state_d    = GRANT;
          cur_d      = winner;
          hold_cnt_d = 8'd1;
          gnt_d      = 16'd1 << winner;
          gnt_idx_d  = winner;
          gnt_vld_d  = 1'b1;
        end
      end
      GRANT: begin
        if (end_normal || end_forced) begin
          state_d    = IDLE;
          ptr_d      = cur_q + 4'd1;
          hold_cnt_d = '0;
          timeout_d  = end_forced;
        end else begin
          // Other request bits are ignored, so the owner is never preempted.
          hold_cnt_d = hold_inc(hold_cnt_q);
          gnt_d      = gnt_q;
          gnt_idx_d  = cur_q;
          gnt_vld_d  = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers. Reset is asynchronous, so the outputs
  // clear at once even in the middle of a grant.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      ptr_q      <= '0;
      cur_q      <= '0;
      hold_cnt_q <= '0;
      gnt_q      <= '0;
      gnt_idx_q  <= '0;
      gnt_vld_q  <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      cur_q      <= cur_d;
      hold_cnt_q <= hold_cnt_d;
      gnt_q      <= gnt_d;
      gnt_idx_q  <= gnt_idx_d;
      gnt_vld_q  <= gnt_vld_d;
      timeout_q  <= timeout_d;
    end
  end

  assign gnt_o     = gnt_q;
  assign gnt_idx_o = gnt_idx_q;
  assign gnt_vld_o = gnt_vld_q;
  assign timeout_o = timeout_q;

endmodule

// File: tb/tb_rr_req_arbiter.sv
// Testbench for rr_req_arbiter. Two instances share the same stimulus:
// instance 0 has a hold limit of 4 and instance 1 has the limit disabled.
module tb_rr_req_arbiter;

  logic        clk;
  logic        rst;
  logic [15:0] req;
  logic        rel;
  logic [15:0] og   [2];
  logic [3:0]  oidx [2];
  logic        ovld [2];
  logic        oto  [2];

  int vectors;
  int errors;

  // Reference model state, one entry per instance.
  logic m_st  [2];
  int   m_ptr [2];
  int   m_cur [2];
  int   m_cnt [2];
  logic m_to  [2];
  int   m_hm  [2];

  rr_req_arbiter #(.HOLD_MAX(4)) u_lim (
    .clk(clk), .rst(rst), .req_i(req), .release_i(rel),
    .gnt_o(og[0]), .gnt_idx_o(oidx[0]), .gnt_vld_o(ovld[0]), .timeout_o(oto[0])
  );

  rr_req_arbiter #(.HOLD_MAX(0)) u_nolim (
    .clk(clk), .rst(rst), .req_i(req), .release_i(rel),
    .gnt_o(og[1]), .gnt_idx_o(oidx[1]), .gnt_vld_o(ovld[1]), .timeout_o(oto[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] exp_gnt(input int k);
    logic [15:0] one;
    one = 16'd1;
    return m_st[k] ? (one << m_cur[k]) : 16'd0;
  endfunction

  function automatic logic [3:0] exp_idx(input int k);
    return m_st[k] ? 4'(m_cur[k]) : 4'd0;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_st[k]  = 1'b0;
      m_ptr[k] = 0;
      m_cur[k] = 0;
      m_cnt[k] = 0;
      m_to[k]  = 1'b0;
    end
  endtask

  // Advance the model by one clock from the given request and release.
  task automatic model_step(input logic [15:0] r, input logic rl);
    for (int k = 0; k < 2; k++) begin
      m_to[k] = 1'b0;
      if (!m_st[k]) begin
        if (r != 16'd0) begin
          int w;
          bit found;
          w = 0;
          found = 0;
          for (int i = 0; i < 16; i++) begin
            if (!found && r[(m_ptr[k] + i) % 16]) begin
              w = (m_ptr[k] + i) % 16;
              found = 1;
            end
          end
          m_st[k]  = 1'b1;
          m_cur[k] = w;
          m_cnt[k] = 1;
        end
      end else begin
        if (rl || !r[m_cur[k]]) begin
          m_st[k]  = 1'b0;
          m_ptr[k] = (m_cur[k] + 1) % 16;
        end else if (m_hm[k] != 0 && m_cnt[k] == m_hm[k]) begin
          m_st[k]  = 1'b0;
          m_ptr[k] = (m_cur[k] + 1) % 16;
          m_to[k]  = 1'b1;
        end else begin
          m_cnt[k] = (m_cnt[k] < 255) ? m_cnt[k] + 1 : 255;
        end
      end
    end
  endtask

  // One clock: update the model from the current inputs, then settle just
  // after the rising edge.
  task automatic tick();
    if (!rst) model_step(req, rel);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req = '0;
    rel = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req = '0;
    rel = 1'b0;
    model_reset();
    #3;
    for (int k = 0; k < 2; k++) begin
      vectors++;
      if (og[k] !== 16'd0 || oidx[k] !== 4'd0 || ovld[k] !== 1'b0 || oto[k] !== 1'b0) begin
        errors++;
        $display("FAIL reset inst%0d: gnt=%h idx=%0d vld=%b to=%b, required all zero",
                 k, og[k], oidx[k], ovld[k], oto[k]);
      end
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_basic();
    do_reset();
    req = 16'h0001;
    tick();
    vectors++;
    if (og[0] !== 16'h0001 || oidx[0] !== 4'd0 || ovld[0] !== 1'b1) begin
      errors++;
      $display("FAIL basic_grant: gnt=%h idx=%0d vld=%b, required 0001/0/1", og[0], oidx[0], ovld[0]);
    end
    rel = 1'b1;
    tick();
    rel = 1'b0;
    vectors++;
    if (ovld[0] !== 1'b0 || oto[0] !== 1'b0 || og[0] !== 16'd0) begin
      errors++;
      $display("FAIL basic_release: vld=%b to=%b gnt=%h, required 0/0/0000", ovld[0], oto[0], og[0]);
    end
    req = '0;
    tick();
  endtask

  task automatic test_sweep();
    do_reset();
    req = 16'hFFFF;
    for (int n = 0; n < 17; n++) begin
      tick();
      vectors++;
      if (ovld[0] !== 1'b1 || oidx[0] !== 4'(n % 16)) begin
        errors++;
        $display("FAIL sweep_grant%0d: vld=%b idx=%0d, required 1/%0d", n, ovld[0], oidx[0], n % 16);
      end
      rel = 1'b1;
      tick();
      rel = 1'b0;
      vectors++;
      if (ovld[0] !== 1'b0 || ovld[1] !== 1'b0) begin
        errors++;
        $display("FAIL sweep_idle%0d: vld=%b/%b, required 0/0", n, ovld[0], ovld[1]);
      end
    end
    req = '0;
    tick();
  endtask

  task automatic test_wrap();
    do_reset();
    req = 16'h8000;
    tick();
    vectors++;
    if (oidx[0] !== 4'd15 || ovld[0] !== 1'b1) begin
      errors++;
      $display("FAIL wrap_g15: idx=%0d vld=%b, required 15/1", oidx[0], ovld[0]);
    end
    rel = 1'b1;
    req = 16'h8001;
    tick();
    rel = 1'b0;
    tick();
    vectors++;
    if (oidx[0] !== 4'd0 || ovld[0] !== 1'b1) begin
      errors++;
      $display("FAIL wrap_after15: idx=%0d vld=%b, required 0/1", oidx[0], ovld[0]);
    end
    rel = 1'b1;
    req = 16'h0020;
    tick();
    rel = 1'b0;
    tick();
    vectors++;
    if (oidx[0] !== 4'd5 || ovld[0] !== 1'b1) begin
      errors++;
      $display("FAIL wrap_g5: idx=%0d vld=%b, required 5/1", oidx[0], ovld[0]);
    end
    rel = 1'b1;
    req = 16'h0021;
    tick();
    rel = 1'b0;
    tick();
    vectors++;
    if (oidx[0] !== 4'd0 || ovld[0] !== 1'b1) begin
      errors++;
      $display("FAIL wrap_after5: idx=%0d vld=%b, required 0/1", oidx[0], ovld[0]);
    end
    req = '0;
    tick();
    tick();
  endtask

  task automatic test_timeout();
    do_reset();
    req = 16'h0010;
    for (int c = 1; c <= 4; c++) begin
      tick();
      vectors++;
      if (ovld[0] !== 1'b1 || oidx[0] !== 4'd4 || oto[0] !== 1'b0) begin
        errors++;
        $display("FAIL timeout_hold%0d: vld=%b idx=%0d to=%b, required 1/4/0", c, ovld[0], oidx[0], oto[0]);
      end
    end
    tick();
    vectors++;
    if (ovld[0] !== 1'b0 || oto[0] !== 1'b1) begin
      errors++;
      $display("FAIL timeout_pulse: vld=%b to=%b, required 0/1", ovld[0], oto[0]);
    end
    vectors++;
    if (ovld[1] !== 1'b1 || oto[1] !== 1'b0) begin
      errors++;
      $display("FAIL timeout_disabled: vld=%b to=%b, required 1/0", ovld[1], oto[1]);
    end
    tick();
    vectors++;
    if (ovld[0] !== 1'b1 || oidx[0] !== 4'd4 || oto[0] !== 1'b0) begin
      errors++;
      $display("FAIL timeout_regrant: vld=%b idx=%0d to=%b, required 1/4/0", ovld[0], oidx[0], oto[0]);
    end
    req = '0;
    tick();
    tick();
  endtask

  task automatic test_limit_tie();
    for (int v = 0; v < 2; v++) begin
      do_reset();
      req = 16'h0010;
      for (int c = 0; c < 4; c++) tick();
      if (v == 0) rel = 1'b1;
      else        req = 16'h0000;
      tick();
      rel = 1'b0;
      vectors++;
      if (ovld[0] !== 1'b0 || oto[0] !== 1'b0) begin
        errors++;
        $display("FAIL limit_tie%0d: vld=%b to=%b, required 0/0", v, ovld[0], oto[0]);
      end
      req = '0;
      tick();
      vectors++;
      if (oto[0] !== 1'b0) begin
        errors++;
        $display("FAIL limit_tie_after%0d: to=%b, required 0", v, oto[0]);
      end
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    req = 16'h0080;
    tick();
    vectors++;
    if (oidx[0] !== 4'd7 || ovld[0] !== 1'b1) begin
      errors++;
      $display("FAIL rstmid_g7: idx=%0d vld=%b, required 7/1", oidx[0], ovld[0]);
    end
    #2;
    rst = 1'b1;
    #1;
    vectors++;
    if (og[0] !== 16'd0 || oidx[0] !== 4'd0 || ovld[0] !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_clear: gnt=%h idx=%0d vld=%b, required 0000/0/0", og[0], oidx[0], ovld[0]);
    end
    #1;
    rst = 1'b0;
    model_reset();
    req = 16'h0081;
    tick();
    vectors++;
    if (oidx[0] !== 4'd0 || ovld[0] !== 1'b1) begin
      errors++;
      $display("FAIL rstmid_restart: idx=%0d vld=%b, required 0/1", oidx[0], ovld[0]);
    end
    req = '0;
    tick();
    tick();
  endtask

  task automatic test_random();
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 7) == 0) begin
        case ($urandom_range(0, 3))
          0: req = '0;
          1: req = 16'd1 << $urandom_range(0, 15);
          2: req = 16'($urandom) & 16'($urandom);
          default: req = 16'($urandom);
        endcase
      end
      rel = ($urandom_range(0, 5) == 0);
      tick();
      for (int k = 0; k < 2; k++) begin
        vectors++;
        if (og[k] !== exp_gnt(k) || oidx[k] !== exp_idx(k) ||
            ovld[k] !== m_st[k] || oto[k] !== m_to[k]) begin
          errors++;
          $display("FAIL random inst%0d cyc%0d: gnt=%h idx=%0d vld=%b to=%b, required %h/%0d/%b/%b",
                   k, n, og[k], oidx[k], ovld[k], oto[k],
                   exp_gnt(k), exp_idx(k), m_st[k], m_to[k]);
        end
      end
    end
    rel = 1'b0;
    req = '0;
    tick();
  endtask

  initial begin
    vectors = 0;
    errors  = 0;
    m_hm[0] = 4;
    m_hm[1] = 0;
    rst = 1'b1;
    req = '0;
    rel = 1'b0;
    test_reset();
    test_basic();
    test_sweep();
    test_wrap();
    test_timeout();
    test_limit_tie();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
